spi_ram: RTL and testbench
==========================

SPI_RAM -- requirements
Module: spi_ram

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256: number of 8-bit memory words.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 8: address width, with 2**ADDR_SIZE = MEM_DEPTH.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port din, input, 10 bits: command word from the SPI slave; [9:8] opcode, [7:0] payload.
REQ-006 The block SHALL have port rx_valid, input, 1 bit: din valid; may stay high for many cycles per word.
REQ-007 The block SHALL have port dout, output, 8 bits: read data returned to the SPI slave.
REQ-008 The block SHALL have port tx_valid, output, 1 bit: dout valid, level-held for serialisation by the SPI slave.

Function
REQ-009 The block SHALL register rx_valid each cycle (rx_valid_q) and accept a command only on a rising edge: rx_valid=1 and rx_valid_q=0.
REQ-010 The block SHALL ignore din on every cycle without an accepted edge, including while rx_valid is held high.
REQ-011 On opcode 2'b00, the block SHALL load wr_addr <= din[ADDR_SIZE-1:0], with upper payload bits ignored.
REQ-012 On opcode 2'b01, the block SHALL perform mem[wr_addr] <= din[7:0] and then wr_addr <= wr_addr+1.
REQ-013 On opcode 2'b10, the block SHALL load rd_addr <= din[ADDR_SIZE-1:0], with upper payload bits ignored.
REQ-014 On opcode 2'b11, the block SHALL set dout <= mem[rd_addr] and tx_valid <= 1 in the accept cycle, so both are visible the cycle after the edge (1-cycle latency), then rd_addr <= rd_addr+1.
REQ-015 Address increments SHALL wrap modulo MEM_DEPTH: MEM_DEPTH-1 goes to 0, with no flag raised.
REQ-016 tx_valid SHALL stay high, and dout SHALL stay stable, until the next accepted command or reset.
REQ-017 An accepted opcode 00, 01 or 10 SHALL clear tx_valid in the same update; dout keeps its last value.
REQ-018 An accepted opcode 11 while tx_valid=1 SHALL keep tx_valid=1 and replace dout with the new word, with no low gap.
REQ-019 Opcode 01 to address A followed by opcode 11 with rd_addr=A SHALL return the newly written byte (write-then-read ordering).
REQ-020 wr_addr and rd_addr SHALL be independent registers; neither command path SHALL modify the other pointer.
REQ-021 Memory SHALL be single-clock, synchronous read, and inferable as block RAM; it is not initialised by reset.
REQ-022 The block SHALL contain no combinational path from din or rx_valid to dout or tx_valid.

Reset
REQ-023 With rst_n=0 at a clock edge, the block SHALL clear dout=8'h00, tx_valid=0, wr_addr=0, rd_addr=0 and rx_valid_q=0.
REQ-024 Memory contents SHALL be retained across reset.
REQ-025 Reset SHALL take priority over a simultaneous accepted command; that command is dropped.
REQ-026 If rx_valid is still high when reset is released, rx_valid_q=0 SHALL make that cycle count as a rising edge, so the pending command executes.

Verification
REQ-027 The bench SHALL apply 00_0x10 then 01_0xA5 then 10_0x10 then 11_xx -> dout=8'hA5 and tx_valid=1 one cycle after the last edge.
REQ-028 The bench SHALL hold rx_valid high 12 cycles with din=01_0x3C after wr_addr=0x20 -> only mem[0x20]=0x3C is written, and wr_addr=0x21.
REQ-029 The bench SHALL set wr_addr=0xFF, write 0x11 then 0x22, set rd_addr=0xFF, then read twice -> reads return 0x11 then 0x22 (wrap to 0x00).
REQ-030 The bench SHALL, with tx_valid=1 and dout=0x11, issue 00_0x05 -> tx_valid=0 next cycle and dout stays 0x11; then issue back-to-back opcode 11 -> tx_valid stays high throughout.
REQ-031 The bench SHALL write 0x77 at 0x40, pulse rst_n=0, then set rd_addr=0x40 and read -> dout=0x77 (memory retained), after outputs read 0/0 during reset.
REQ-032 The bench SHALL assert rst_n=0 in the same cycle as an opcode-01 edge -> no memory write occurs and all registers hold their reset values.

Source files
------------

// File: rtl/spi_ram.sv
// ----------------------------------------------------------------------------
// spi_ram
//   Byte-wide command-driven RAM that sits behind an SPI slave. The slave
//   delivers 10-bit command words; the RAM acts on each word once, on the
//   rising edge of rx_valid. Read data is returned on dout with tx_valid held
//   high until the next accepted command.
//
//   Command word din[9:8] opcode, din[7:0] payload:
//     2'b00  load write pointer from payload
//     2'b01  write payload at write pointer, then advance write pointer
//     2'b10  load read pointer from payload
//     2'b11  fetch word at read pointer onto dout, then advance read pointer
//
// Ports
//   clk       in   clock, all state updates on its rising edge
//   rst_n     in   synchronous active-low reset (memory contents retained)
//   din       in   [9:0] command word from the SPI slave
//   rx_valid  in   din valid, may be held high across many cycles
//   dout      out  [7:0] read data, registered
//   tx_valid  out  dout valid, registered and level-held
// ----------------------------------------------------------------------------
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);

  localparam logic [1:0] OP_SET_WR = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SET_RD = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  localparam logic [ADDR_SIZE-1:0] ADDR_ONE = ADDR_SIZE'(1);

  logic                 rx_valid_q;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]           dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;

  logic                 accept_s;
  logic [1:0]           opcode_s;
  logic                 mem_we_s;

  // Not reset: contents survive rst_n so the array can map onto block RAM.
  logic [7:0] mem [MEM_DEPTH];

  // Command decode and next-state computation for pointers and outputs.
  always_comb begin
    accept_s   = rx_valid & ~rx_valid_q;
    opcode_s   = din[9:8];
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    mem_we_s   = 1'b0;
    if (accept_s) begin
      case (opcode_s)
        OP_SET_WR: begin
          wr_addr_d  = din[ADDR_SIZE-1:0];
          tx_valid_d = 1'b0;
        end
        OP_WRITE: begin
          // Pointer width equals log2(MEM_DEPTH), so the increment wraps.
          mem_we_s   = 1'b1;
          wr_addr_d  = wr_addr_q + ADDR_ONE;
          tx_valid_d = 1'b0;
        end
        OP_SET_RD: begin
          rd_addr_d  = din[ADDR_SIZE-1:0];
          tx_valid_d = 1'b0;
        end
        OP_READ: begin
          // Read of a registered address into a registered output keeps the
          // array a synchronous-read RAM; a back-to-back read keeps tx_valid up.
          dout_d     = mem[rd_addr_q];
          rd_addr_d  = rd_addr_q + ADDR_ONE;
          tx_valid_d = 1'b1;
        end
        default: begin
          tx_valid_d = tx_valid_q;
        end
      endcase
    end else begin
      mem_we_s   = 1'b0;
      tx_valid_d = tx_valid_q;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Memory write port; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we_s) begin
      mem[wr_addr_q] <= din[7:0];
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_spi_ram.sv
// ----------------------------------------------------------------------------
// tb_spi_ram
//   Self-checking bench for spi_ram. A behavioural model (byte array plus two
//   integer pointers) predicts dout/tx_valid for directed scenarios and a run
//   of random commands. Inputs change on the falling edge; outputs are
//   sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_spi_ram;

  logic       clk;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0] mem_m [256];
  int         wr_m;
  int         rd_m;
  logic [7:0] dout_m;
  logic       txv_m;

  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    wr_m   = 0;
    rd_m   = 0;
    dout_m = 8'h00;
    txv_m  = 1'b0;
  endfunction

  function automatic void model_cmd(input logic [1:0] op, input logic [7:0] pl);
    case (op)
      2'd0: begin wr_m = pl; txv_m = 1'b0; end
      2'd1: begin mem_m[wr_m] = pl; wr_m = (wr_m + 1) % 256; txv_m = 1'b0; end
      2'd2: begin rd_m = pl; txv_m = 1'b0; end
      default: begin dout_m = mem_m[rd_m]; rd_m = (rd_m + 1) % 256; txv_m = 1'b1; end
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, "_txv"}, 32'(tx_valid), 32'(txv_m));
    check_eq({tag, "_dout"}, 32'(dout), 32'(dout_m));
  endtask

  // One command: rx_valid high for 'hold' cycles, then low so the next is a new edge.
  task automatic send(input logic [1:0] op, input logic [7:0] pl, input int hold);
    @(negedge clk);
    check_outputs("stable");
    din      = {op, pl};
    rx_valid = 1'b1;
    model_cmd(op, pl);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_outputs("cmd");
    end
    rx_valid = 1'b0;
    din      = 10'($urandom);
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    din      = 10'h000;
    model_reset();
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_dout", 32'(dout), 32'h0);
    check_eq("rst_txv", 32'(tx_valid), 32'h0);
    rst_n = 1'b1;

    // fill the whole memory so every later read has a known expectation
    send(2'b00, 8'h00, 1);
    for (int i = 0; i < 256; i++) send(2'b01, 8'($urandom), 1);

    // write-then-read basic sequence
    send(2'b00, 8'h10, 1);
    send(2'b01, 8'hA5, 1);
    send(2'b10, 8'h10, 1);
    send(2'b11, 8'($urandom), 1);
    check_eq("basic_dout", 32'(dout), 32'hA5);
    check_eq("basic_txv", 32'(tx_valid), 32'h1);

    // rx_valid held 12 cycles: a single write only
    send(2'b00, 8'h21, 1);
    send(2'b01, 8'h5A, 1);
    send(2'b00, 8'h20, 1);
    send(2'b01, 8'h3C, 12);
    send(2'b01, 8'h99, 1);
    send(2'b10, 8'h20, 1);
    send(2'b11, 8'h00, 1);
    check_eq("hold_m20", 32'(dout), 32'h3C);
    send(2'b11, 8'h00, 1);
    check_eq("hold_m21", 32'(dout), 32'h99);
    send(2'b11, 8'h00, 1);
    check_eq("hold_m22", 32'(dout), 32'(mem_m[8'h22]));

    // pointer wrap at the top of memory
    send(2'b00, 8'hFF, 1);
    send(2'b01, 8'h11, 1);
    send(2'b01, 8'h22, 1);
    send(2'b10, 8'hFF, 1);
    send(2'b11, 8'h00, 1);
    check_eq("wrap_rd0", 32'(dout), 32'h11);
    send(2'b11, 8'h00, 1);
    check_eq("wrap_rd1", 32'(dout), 32'h22);

    // tx_valid drop on non-read, then back-to-back reads
    send(2'b10, 8'hFF, 1);
    send(2'b11, 8'h00, 1);
    check_eq("drop_pre_dout", 32'(dout), 32'h11);
    send(2'b00, 8'h05, 1);
    check_eq("drop_txv", 32'(tx_valid), 32'h0);
    check_eq("drop_dout", 32'(dout), 32'h11);
    for (int i = 0; i < 3; i++) begin
      send(2'b11, 8'h00, 1);
      check_eq("b2b_txv", 32'(tx_valid), 32'h1);
    end

    // memory retained across reset
    send(2'b00, 8'h40, 1);
    send(2'b01, 8'h77, 1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("rstp_dout", 32'(dout), 32'h0);
      check_eq("rstp_txv", 32'(tx_valid), 32'h0);
    end
    rst_n = 1'b1;
    model_reset();
    send(2'b10, 8'h40, 1);
    send(2'b11, 8'h00, 1);
    check_eq("retain_dout", 32'(dout), 32'h77);

    // reset coincident with a write edge: write dropped, pointers cleared
    send(2'b00, 8'h50, 1);
    @(negedge clk);
    din      = {2'b01, 8'hEE};
    rx_valid = 1'b1;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    model_reset();
    check_eq("rstw_dout", 32'(dout), 32'h0);
    check_eq("rstw_txv", 32'(tx_valid), 32'h0);
    send(2'b10, 8'h50, 1);
    send(2'b11, 8'h00, 1);
    check_eq("rstw_m50", 32'(dout), 32'(mem_m[8'h50]));
    send(2'b01, 8'h66, 1);
    send(2'b10, 8'h00, 1);
    send(2'b11, 8'h00, 1);
    check_eq("rstw_wr0", 32'(dout), 32'h66);

    // rx_valid high across reset release executes the pending read
    @(negedge clk);
    rst_n    = 1'b0;
    din      = {2'b11, 8'h00};
    rx_valid = 1'b1;
    @(negedge clk);
    check_eq("pend_rst_txv", 32'(tx_valid), 32'h0);
    rst_n = 1'b1;
    model_reset();
    model_cmd(2'b11, 8'h00);
    @(negedge clk);
    rx_valid = 1'b0;
    check_eq("pend_txv", 32'(tx_valid), 32'h1);
    check_eq("pend_dout", 32'(dout), 32'h66);

    // random command stream against the model
    for (int n = 0; n < 1500; n++) begin
      send(2'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(1, 3)));
    end

    @(negedge clk);
    check_outputs("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
